// File: rtl/axi_stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_stream_arb_pkg
// Shared stream types for the AXI-Stream packet arbiter and its neighbours.
//   arb_state_t  : arbiter state (IDLE waits for a request, PASS forwards one
//                  packet from the granted source)
//   out_entry_t  : one output pipeline entry (data, last, user, src_id)
//   fifo_entry_t : one stream beat as stored by FIFOs in the same stream path
//   rr_next()    : round-robin successor of an index, wrapping at n
// Payload fields are sized for the widest stream in this codebase; a module
// with narrower streams uses the low bits and leaves the rest at zero.
// -----------------------------------------------------------------------------
package axi_stream_arb_pkg;

    localparam int STREAM_MAX_DATA_W = 256;
    localparam int STREAM_MAX_USER_W = 64;
    localparam int STREAM_MAX_ID_W   = 4;   // enough for 16 sources

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [STREAM_MAX_DATA_W-1:0] data;
        logic                         last;
        logic [STREAM_MAX_USER_W-1:0] user;
        logic [STREAM_MAX_ID_W-1:0]   src_id;
    } out_entry_t;

    typedef struct packed {
        logic [STREAM_MAX_DATA_W-1:0] data;
        logic                         last;
        logic [STREAM_MAX_USER_W-1:0] user;
    } fifo_entry_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_stream_arb_if.sv
// -----------------------------------------------------------------------------
// axi_if
// AXI-Stream bundle: tdata, tlast, tuser, tvalid, tready.
//   master modport : drives tdata/tlast/tuser/tvalid, receives tready
//   slave  modport : receives tdata/tlast/tuser/tvalid, drives tready
// -----------------------------------------------------------------------------
interface axi_if
    import axi_stream_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int USER_W = 8
) ();

    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tuser, output tvalid,
                    input  tready);
    modport slave  (input  tdata, input  tlast, input  tuser, input  tvalid,
                    output tready);

endinterface

// File: rtl/axi_stream_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first asserted request found
// when scanning ptr, ptr+1, ... wrapping modulo N.
//   req     : request vector, one bit per source
//   ptr     : index the search starts from
//   gnt_idx : winning index (0 when nothing requests)
//   gnt_any : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick
    import axi_stream_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int W = $clog2(N);

    // Scan from the farthest offset down to offset 0 so the candidate closest
    // to ptr is the last one written and therefore wins.
    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx[W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_stream_arb.sv
// -----------------------------------------------------------------------------
// axi_stream_arb
// Merges N_SRC AXI-Stream sources into one output, one whole packet at a
// time, with round-robin fairness between packets.
//   clk, rst   : clock and synchronous active-high reset
//   s_axi_if[] : source streams (slave side)
//   m_axi_if   : merged output stream (master side), one-entry output register
//   src_en     : per-source enable, looked at only while choosing a source
//   m_src_id   : source index of the beat held in the output register
//   busy       : high while a packet is being forwarded
// -----------------------------------------------------------------------------
module axi_stream_arb
    import axi_stream_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int USER_W = 8,
    parameter int N_SRC  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_if.slave                     s_axi_if [N_SRC],
    axi_if.master                    m_axi_if,
    input  logic [N_SRC-1:0]         src_en,
    output logic [$clog2(N_SRC)-1:0] m_src_id,
    output logic                     busy
);

    localparam int GW = $clog2(N_SRC);

    generate
        if (N_SRC < 2 || N_SRC > 16) begin : g_bad_n_src
            $error("axi_stream_arb: N_SRC must be in 2..16");
        end
    endgenerate

    // State
    arb_state_t        r_state;
    logic [GW-1:0]     r_grant;
    logic [GW-1:0]     r_rr_ptr;
    logic              r_out_valid;
    out_entry_t        r_out;

    arb_state_t        w_state_next;
    logic [GW-1:0]     w_grant_next;
    logic [GW-1:0]     w_rr_ptr_next;

    // Source streams flattened into arrays so they can be indexed by grant
    logic [N_SRC-1:0]  w_valid;
    logic [N_SRC-1:0]  w_last;
    logic [DATA_W-1:0] w_data [N_SRC];
    logic [USER_W-1:0] w_user [N_SRC];
    logic [N_SRC-1:0]  w_tready;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign w_valid[gi]          = s_axi_if[gi].tvalid;
            assign w_last[gi]           = s_axi_if[gi].tlast;
            assign w_data[gi]           = s_axi_if[gi].tdata;
            assign w_user[gi]           = s_axi_if[gi].tuser;
            assign s_axi_if[gi].tready  = w_tready[gi];
        end
    endgenerate

    // Arbitration
    logic [N_SRC-1:0]  w_req;
    logic [GW-1:0]     w_pick_idx;
    logic              w_pick_any;

    assign w_req = w_valid & src_en;

    rr_pick #(
        .N (N_SRC)
    ) u_rr_pick (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .gnt_any (w_pick_any)
    );

    // Output register can take a beat when empty or when it is being drained
    // this cycle; this is the only path from m tready back to the sources.
    logic w_out_ready;
    logic w_sel_valid;
    logic w_sel_last;
    logic w_accept;

    assign w_out_ready = !r_out_valid || m_axi_if.tready;
    assign w_sel_valid = w_valid[r_grant];
    assign w_sel_last  = w_last[r_grant];
    assign w_accept    = (r_state == ST_PASS) && w_sel_valid && w_out_ready;

    always_comb begin
        w_tready = '0;
        if (r_state == ST_PASS) begin
            w_tready[r_grant] = w_out_ready;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_rr_ptr_next = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_next = ST_PASS;
                    w_grant_next = w_pick_idx;
                end
            end
            ST_PASS: begin
                // Only the end of a packet releases the grant, so packets
                // never interleave and src_en changes wait for the next pick.
                if (w_accept && w_sel_last) begin
                    w_state_next  = ST_IDLE;
                    w_rr_ptr_next = GW'(rr_next(int'(r_grant), N_SRC));
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_rr_ptr <= w_rr_ptr_next;
            // A load wins over a pop, so load+pop in one cycle keeps valid.
            if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (m_axi_if.tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Output entry. Payload is left unreset; only the source id is cleared.
    out_entry_t w_load;

    always_comb begin
        w_load                     = '0;
        w_load.data[DATA_W-1:0]    = w_data[r_grant];
        w_load.last                = w_sel_last;
        w_load.user[USER_W-1:0]    = w_user[r_grant];
        w_load.src_id[GW-1:0]      = r_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out.src_id <= '0;
        end else if (w_accept) begin
            r_out <= w_load;
        end
    end

    // Upper payload bits are always zero here and intentionally unread.
    logic w_unused_out;
    assign w_unused_out = ^r_out;

    assign m_axi_if.tvalid = r_out_valid;
    assign m_axi_if.tdata  = r_out.data[DATA_W-1:0];
    assign m_axi_if.tlast  = r_out.last;
    assign m_axi_if.tuser  = r_out.user[USER_W-1:0];
    assign m_src_id        = r_out.src_id[GW-1:0];
    assign busy            = (r_state == ST_PASS);

endmodule

// File: tb/tb_axi_stream_arb.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_arb
// Packet-level sources and a randomised sink drive the arbiter. A reference
// model of the arbitration rules predicts busy, every tready, and the output
// register contents each cycle; directed scenarios pin the model with
// hand-derived sequences.
// -----------------------------------------------------------------------------
module tb_axi_stream_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int UW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]  src_en = '1;
    logic [1:0]    m_src_id;
    logic          busy;
    logic          m_ready = 1'b0;

    logic [N-1:0]  drv_valid = '0;
    logic [N-1:0]  drv_last  = '0;
    logic [DW-1:0] drv_data [N];
    logic [UW-1:0] drv_user [N];
    logic [N-1:0]  dut_ready;

    axi_if #(.DATA_W(DW), .USER_W(UW)) s_if [N] ();
    axi_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bind
            assign s_if[gi].tvalid = drv_valid[gi];
            assign s_if[gi].tlast  = drv_last[gi];
            assign s_if[gi].tdata  = drv_data[gi];
            assign s_if[gi].tuser  = drv_user[gi];
            assign dut_ready[gi]   = s_if[gi].tready;
        end
    endgenerate

    assign m_if.tready = m_ready;

    axi_stream_arb #(.DATA_W(DW), .USER_W(UW), .N_SRC(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axi_if (s_if),
        .m_axi_if (m_if),
        .src_en   (src_en),
        .m_src_id (m_src_id),
        .busy     (busy)
    );

    // Stimulus state
    int pkts [N][$];        // remaining packet lengths per source
    int beat_idx [N];
    int vprob = 100;
    int rprob = 100;
    int ready_q [$];
    bit verbose = 1'b1;

    typedef struct {
        int            id;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         out_log [$];
    logic [DW-1:0] sent_log [$];
    int            tv_trace [$];
    int            starts [$];

    // Reference model
    bit            md_pass;
    int            md_grant, md_rr, md_id;
    bit            md_outv;
    logic [DW-1:0] md_data;
    logic          md_last;
    logic [UW-1:0] md_user;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] exp_r;
        logic [N-1:0] took;
        bit           out_rdy, acc;
        int           j;
        beat_t        b;
        // Drive sources and sink
        for (int i = 0; i < N; i++) begin
            if (!drv_valid[i] && pkts[i].size() > 0 && int'($urandom_range(99)) < vprob) begin
                drv_valid[i] = 1'b1;
                drv_data[i]  = $urandom;
                drv_user[i]  = UW'($urandom);
                drv_last[i]  = (beat_idx[i] == pkts[i][0] - 1);
            end
        end
        if (ready_q.size() > 0) m_ready = (ready_q.pop_front() != 0);
        else                    m_ready = int'($urandom_range(99)) < rprob;
        #1;
        for (int i = 0; i < N; i++)
            exp_r[i] = md_pass && (md_grant == i) && (!md_outv || m_ready);
        chk("s_tready", 64'(dut_ready), 64'(exp_r));
        took = drv_valid & dut_ready & {N{!rst}};
        if (!rst && m_if.tvalid && m_ready) begin
            b.id = int'(m_src_id); b.last = m_if.tlast; b.data = m_if.tdata;
            out_log.push_back(b);
            if (verbose)
                $display("beat src=%0d data=%08h user=%02h last=%0d", m_src_id, m_if.tdata, m_if.tuser, m_if.tlast);
        end
        // Model: what the registers must hold after this edge
        if (rst) begin
            md_pass = 0; md_grant = 0; md_rr = 0; md_outv = 0; md_id = 0;
        end else begin
            out_rdy = !md_outv || m_ready;
            acc     = md_pass && drv_valid[md_grant] && out_rdy;
            if (acc) begin
                md_outv = 1; md_data = drv_data[md_grant]; md_last = drv_last[md_grant];
                md_user = drv_user[md_grant]; md_id = md_grant;
            end else if (md_outv && m_ready) begin
                md_outv = 0;
            end
            if (!md_pass) begin
                for (int k = 0; k < N; k++) begin
                    j = (md_rr + k) % N;
                    if (!md_pass && drv_valid[j] && src_en[j]) begin
                        md_grant = j; md_pass = 1;
                    end
                end
            end else if (acc && drv_last[md_grant]) begin
                md_pass = 0; md_rr = (md_grant + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
        // Sources advance past accepted beats
        for (int i = 0; i < N; i++) begin
            if (took[i]) begin
                sent_log.push_back(drv_data[i]);
                beat_idx[i]++;
                if (drv_last[i]) begin
                    beat_idx[i] = 0;
                    if (pkts[i].size() > 0) void'(pkts[i].pop_front());
                end
                drv_valid[i] = 1'b0;
            end
        end
        chk("m_tvalid", 64'(m_if.tvalid), 64'(md_outv));
        chk("busy", 64'(busy), 64'(md_pass));
        chk("m_src_id", 64'(m_src_id), 64'(md_id));
        if (md_outv) begin
            chk("m_tdata", 64'(m_if.tdata), 64'(md_data));
            chk("m_tlast", 64'(m_if.tlast), 64'(md_last));
            chk("m_tuser", 64'(m_if.tuser), 64'(md_user));
        end
        tv_trace.push_back(int'(m_if.tvalid));
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            pkts[i].delete();
            beat_idx[i]  = 0;
            drv_valid[i] = 1'b0;
        end
    endtask

    task automatic reset_all();
        clear_sources();
        ready_q.delete();
        vprob = 100; rprob = 100; src_en = '1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_log.delete(); sent_log.delete(); tv_trace.delete();
    endtask

    task automatic get_starts();
        starts.delete();
        for (int k = 0; k < out_log.size(); k++)
            if (k == 0 || out_log[k-1].last) starts.push_back(out_log[k].id);
    endtask

    int exp_tv1 [9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    int exp_id1 [6]  = '{0, 0, 0, 2, 2, 2};
    int exp_ls1 [6]  = '{0, 0, 1, 0, 0, 1};
    int exp_st2 [5]  = '{0, 1, 2, 3, 0};
    int exp_st4 [5]  = '{0, 2, 3, 2, 3};
    int exp_tv6 [8]  = '{0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        int cnt;
        for (int i = 0; i < N; i++) begin
            drv_data[i] = '0; drv_user[i] = '0; beat_idx[i] = 0;
        end
        md_pass = 0; md_grant = 0; md_rr = 0; md_outv = 0; md_id = 0;
        md_data = '0; md_last = 0; md_user = '0;

        // Reset state
        reset_all();
        chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tready", 64'(dut_ready), 64'd0);
        chk("rst_src_id", 64'(m_src_id), 64'd0);

        // Two 3-beat packets, src0 then src2, one bubble between them
        pkts[0].push_back(3); pkts[2].push_back(3);
        repeat (12) cycle();
        for (int k = 0; k < 9; k++) chk($sformatf("s1_tvalid[%0d]", k), 64'(tv_trace[k]), 64'(exp_tv1[k]));
        chk("s1_beats", 64'(out_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < out_log.size(); k++) begin
            chk($sformatf("s1_id[%0d]", k), 64'(out_log[k].id), 64'(exp_id1[k]));
            chk($sformatf("s1_last[%0d]", k), 64'(out_log[k].last), 64'(exp_ls1[k]));
        end

        // All sources busy with 2-beat packets: rotation 0,1,2,3,0
        reset_all();
        for (int i = 0; i < N; i++) begin pkts[i].push_back(2); pkts[i].push_back(2); end
        repeat (30) cycle();
        get_starts();
        chk("s2_beats", 64'(out_log.size()), 64'd16);
        for (int k = 0; k < 5 && k < starts.size(); k++)
            chk($sformatf("s2_order[%0d]", k), 64'(starts[k]), 64'(exp_st2[k]));

        // Stalled sink during src1's packet
        reset_all();
        pkts[1].push_back(4);
        ready_q = '{1, 1, 0, 0, 1};
        repeat (12) cycle();
        chk("s3_beats", 64'(out_log.size()), 64'd4);
        chk("s3_hold_a", 64'(tv_trace[2]), 64'd1);
        chk("s3_hold_b", 64'(tv_trace[3]), 64'd1);
        for (int k = 0; k < out_log.size() && k < sent_log.size(); k++) begin
            chk($sformatf("s3_data[%0d]", k), 64'(out_log[k].data), 64'(sent_log[k]));
            chk($sformatf("s3_id[%0d]", k), 64'(out_log[k].id), 64'd1);
        end

        // Masked src1; src0 disabled mid-packet still finishes
        reset_all();
        for (int i = 0; i < N; i++) begin pkts[i].push_back(3); pkts[i].push_back(3); end
        src_en = 4'b1101;
        repeat (2) cycle();
        src_en = 4'b1100;
        repeat (30) cycle();
        get_starts();
        chk("s4_packets", 64'(starts.size()), 64'd5);
        for (int k = 0; k < 5 && k < starts.size(); k++)
            chk($sformatf("s4_order[%0d]", k), 64'(starts[k]), 64'(exp_st4[k]));
        cnt = 0;
        foreach (out_log[k]) if (out_log[k].id == 1) cnt++;
        chk("s4_src1_beats", 64'(cnt), 64'd0);

        // Reset in the middle of a 5-beat packet
        reset_all();
        pkts[1].push_back(1);
        repeat (4) cycle();
        pkts[3].push_back(5);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("s5_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("s5_busy", 64'(busy), 64'd0);
        chk("s5_tready", 64'(dut_ready), 64'd0);
        clear_sources();
        out_log.delete();
        pkts[1].push_back(1); pkts[2].push_back(1); pkts[3].push_back(1);
        repeat (10) cycle();
        chk("s5_beats", 64'(out_log.size()), 64'd3);
        if (out_log.size() > 0) chk("s5_first_src", 64'(out_log[0].id), 64'd1);

        // Back-to-back single-beat packets from src3
        reset_all();
        for (int k = 0; k < 4; k++) pkts[3].push_back(1);
        repeat (10) cycle();
        for (int k = 0; k < 8; k++) chk($sformatf("s6_tvalid[%0d]", k), 64'(tv_trace[k]), 64'(exp_tv6[k]));
        chk("s6_beats", 64'(out_log.size()), 64'd4);
        foreach (out_log[k]) begin
            chk($sformatf("s6_id[%0d]", k), 64'(out_log[k].id), 64'd3);
            chk($sformatf("s6_last[%0d]", k), 64'(out_log[k].last), 64'd1);
        end

        // Randomised traffic, sink backpressure, enable changes and resets
        verbose = 1'b0;
        for (int seg = 0; seg < 3; seg++) begin
            reset_all();
            vprob = int'($urandom_range(100, 40));
            rprob = int'($urandom_range(100, 30));
            repeat (700) begin
                for (int i = 0; i < N; i++)
                    if (pkts[i].size() == 0 && $urandom_range(3) == 0)
                        pkts[i].push_back(int'($urandom_range(5, 1)));
                if ($urandom_range(19) == 0) src_en = N'($urandom);
                rst = ($urandom_range(249) == 0);
                cycle();
            end
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
